// File: rtl/nco_pkg.sv
// Shared types and default widths for the NCO frequency-sweep sequencer.
package nco_pkg;

  localparam int NCO_W       = 32;
  localparam int NCO_DWELL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DONE  = 2'd2
  } nco_state_e;

endpackage : nco_pkg

// File: rtl/nco_sweep_ctrl_if.sv
// Control/config inputs and accumulator-side outputs of the sweep sequencer.
interface nco_sweep_ctrl_if
  import nco_pkg::*;
#(
  parameter int W       = NCO_W,
  parameter int DWELL_W = NCO_DWELL_W
);

  logic               start_i;
  logic               abort_i;
  logic               cont_i;
  logic               up_i;
  logic [W-1:0]       f_start_i;
  logic [W-1:0]       f_stop_i;
  logic [W-1:0]       f_step_i;
  logic [DWELL_W-1:0] dwell_i;

  logic [W-1:0]       p_inc_o;
  logic               valid_o;
  logic               acc_rst_o;
  logic               busy_o;
  logic               step_o;
  logic               done_o;

  modport master (
    output start_i, abort_i, cont_i, up_i, f_start_i, f_stop_i, f_step_i, dwell_i,
    input  p_inc_o, valid_o, acc_rst_o, busy_o, step_o, done_o
  );

  modport slave (
    input  start_i, abort_i, cont_i, up_i, f_start_i, f_stop_i, f_step_i, dwell_i,
    output p_inc_o, valid_o, acc_rst_o, busy_o, step_o, done_o
  );

endinterface : nco_sweep_ctrl_if

// File: rtl/nco_step_calc.sv
// Next increment value with clamp-to-stop, plus terminal-value detection.
module nco_step_calc #(
  parameter int W = 32
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] stop,
  input  logic [W-1:0] step,
  input  logic         up,
  output logic [W-1:0] next,
  output logic         term
);

  logic [W:0] sum;
  logic       past_stop;
  logic       beyond;

  // The extra bit catches wrap-around in either direction so it clamps instead.
  assign sum       = up ? ({1'b0, cur} + {1'b0, step}) : ({1'b0, cur} - {1'b0, step});
  assign past_stop = sum[W] | (up ? (sum[W-1:0] > stop) : (sum[W-1:0] < stop));
  assign next      = past_stop ? stop : sum[W-1:0];

  assign beyond    = up ? (cur > stop) : (cur < stop);
  assign term      = (cur == stop) | (step == '0) | beyond;

endmodule : nco_step_calc

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding the NCO phase accumulator.
// Optional NCO_SWEEP_PHASE_RST_EN: pulse acc_rst_o at each sweep start and wrap.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int W       = NCO_W,
  parameter int DWELL_W = NCO_DWELL_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  nco_sweep_ctrl_if.slave  bus
);

  typedef struct packed {
    logic               cont;
    logic               up;
    logic [W-1:0]       f_start;
    logic [W-1:0]       f_stop;
    logic [W-1:0]       f_step;
    logic [DWELL_W-1:0] dwell;
  } cfg_t;

  nco_state_e         state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [W-1:0]       p_inc_q, p_inc_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               step_q, step_d;

  logic [W-1:0]       next_val;
  logic               term;
  logic               launch;
  logic               hold_end;
  logic               wrap;

  nco_step_calc #(.W(W)) u_step_calc (
    .cur  (p_inc_q),
    .stop (cfg_q.f_stop),
    .step (cfg_q.f_step),
    .up   (cfg_q.up),
    .next (next_val),
    .term (term)
  );

  assign launch   = (state_q == ST_IDLE) && bus.start_i && !bus.abort_i;
  assign hold_end = (state_q == ST_DWELL) && !bus.abort_i && (cnt_q == '0);
  assign wrap     = hold_end && term && cfg_q.cont;
  assign step_d   = hold_end && (!term || cfg_q.cont);

  // NOTE: every signal written here gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    p_inc_d = p_inc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          cfg_d   = '{cont:    bus.cont_i,
                      up:      bus.up_i,
                      f_start: bus.f_start_i,
                      f_stop:  bus.f_stop_i,
                      f_step:  bus.f_step_i,
                      dwell:   bus.dwell_i};
          p_inc_d = bus.f_start_i;
          cnt_d   = bus.dwell_i;
          state_d = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (bus.abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (!term) begin
          p_inc_d = next_val;
          cnt_d   = cfg_q.dwell;
        end else if (cfg_q.cont) begin
          p_inc_d = cfg_q.f_start;
          cnt_d   = cfg_q.dwell;
        end else begin
          p_inc_d = cfg_q.f_stop;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      p_inc_q <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      p_inc_q <= p_inc_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  assign bus.p_inc_o = p_inc_q;
  assign bus.valid_o = (state_q == ST_DWELL);
  assign bus.busy_o  = (state_q == ST_DWELL);
  assign bus.done_o  = (state_q == ST_DONE);
  assign bus.step_o  = step_q;

`ifdef NCO_SWEEP_PHASE_RST_EN
  logic acc_rst_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_rst_q <= 1'b0;
    else         acc_rst_q <= launch | wrap;
  end

  assign bus.acc_rst_o = acc_rst_q;
`else
  // Free-running phase: wraps still reload f_start, but the accumulator is never cleared.
  logic unused_wrap;
  assign unused_wrap   = wrap;
  assign bus.acc_rst_o = 1'b0 & unused_wrap;
`endif

endmodule : nco_sweep_ctrl

// File: tb/tb_nco_sweep_ctrl.sv
// Directed, table-driven bench for nco_sweep_ctrl with hand-computed sweep traces.
module tb_nco_sweep_ctrl;

  typedef struct {
    logic        up;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    int          n;
    logic [31:0] vals [6];
    logic        poke;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl [7];

  nco_sweep_ctrl_if #(.W(32), .DWELL_W(16)) bus ();

  nco_sweep_ctrl #(.W(32), .DWELL_W(16)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic up, input logic [31:0] fs, input logic [31:0] fe,
                              input logic [31:0] st, input logic [15:0] dw, input int n,
                              input logic [31:0] v0, input logic [31:0] v1,
                              input logic [31:0] v2, input logic [31:0] v3,
                              input logic poke);
    vec_t v;
    v.up = up; v.f_start = fs; v.f_stop = fe; v.f_step = st; v.dwell = dw; v.n = n;
    v.vals[0] = v0; v.vals[1] = v1; v.vals[2] = v2; v.vals[3] = v3;
    v.vals[4] = '0; v.vals[5] = '0;
    v.poke = poke;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_acc_rst(input string name, input logic first);
`ifdef NCO_SWEEP_PHASE_RST_EN
    check(name, bus.acc_rst_o, first);
`else
    check(name, bus.acc_rst_o, 1'b0);
`endif
  endtask

  task automatic drive_cfg(input logic cont, input logic up, input logic [31:0] fs,
                           input logic [31:0] fe, input logic [31:0] st, input logic [15:0] dw);
    bus.cont_i = cont; bus.up_i = up; bus.f_start_i = fs;
    bus.f_stop_i = fe; bus.f_step_i = st; bus.dwell_i = dw;
  endtask

  // Single sweep: each listed value for dwell+1 cycles, one DONE cycle, then IDLE.
  task automatic run_vec(input int id, input vec_t v);
    drive_cfg(1'b0, v.up, v.f_start, v.f_stop, v.f_step, v.dwell);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      for (int h = 0; h <= int'(v.dwell); h++) begin
        check($sformatf("v%0d k%0d h%0d p_inc", id, k, h), bus.p_inc_o, v.vals[k]);
        check($sformatf("v%0d k%0d h%0d valid", id, k, h), bus.valid_o, 1'b1);
        check($sformatf("v%0d k%0d h%0d busy", id, k, h), bus.busy_o, 1'b1);
        check($sformatf("v%0d k%0d h%0d step", id, k, h), bus.step_o, (k > 0 && h == 0));
        check($sformatf("v%0d k%0d h%0d done", id, k, h), bus.done_o, 1'b0);
        exp_acc_rst($sformatf("v%0d k%0d h%0d acc_rst", id, k, h), (k == 0 && h == 0));
        bus.start_i = v.poke && k == 1 && h == 0;
        if (bus.start_i) drive_cfg(1'b1, ~v.up, 32'd999, 32'd5, 32'd1, 16'd7);
        tick();
      end
    end
    bus.start_i = 1'b0;
    check($sformatf("v%0d DONE done", id), bus.done_o, 1'b1);
    check($sformatf("v%0d DONE valid", id), bus.valid_o, 1'b0);
    check($sformatf("v%0d DONE busy", id), bus.busy_o, 1'b0);
    check($sformatf("v%0d DONE step", id), bus.step_o, 1'b0);
    check($sformatf("v%0d DONE p_inc", id), bus.p_inc_o, v.f_stop);
    tick();
    check($sformatf("v%0d IDLE done", id), bus.done_o, 1'b0);
    check($sformatf("v%0d IDLE valid", id), bus.valid_o, 1'b0);
    check($sformatf("v%0d IDLE p_inc", id), bus.p_inc_o, v.f_stop);
  endtask

  initial begin
    tbl[0] = mk(1'b1, 32'd100, 32'd130, 32'd10, 16'd2, 4, 32'd100, 32'd110, 32'd120, 32'd130, 1'b1);
    tbl[1] = mk(1'b1, 32'd100, 32'd125, 32'd10, 16'd0, 4, 32'd100, 32'd110, 32'd120, 32'd125, 1'b0);
    tbl[2] = mk(1'b0, 32'd5,   32'd0,   32'd10, 16'd0, 2, 32'd5,   32'd0,   32'd0,   32'd0,   1'b0);
    tbl[3] = mk(1'b1, 32'd7,   32'd50,  32'd0,  16'd3, 1, 32'd7,   32'd0,   32'd0,   32'd0,   1'b0);
    tbl[4] = mk(1'b1, 32'd200, 32'd100, 32'd10, 16'd1, 1, 32'd200, 32'd0,   32'd0,   32'd0,   1'b0);
    tbl[5] = mk(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd0, 2,
                32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
    tbl[6] = mk(1'b0, 32'd50,  32'd20,  32'd15, 16'd1, 3, 32'd50,  32'd35,  32'd20,  32'd0,   1'b0);

    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    drive_cfg(1'b0, 1'b1, '0, '0, '0, '0);
    #12;
    check("reset p_inc", bus.p_inc_o, 32'd0);
    check("reset valid", bus.valid_o, 1'b0);
    check("reset busy", bus.busy_o, 1'b0);
    check("reset step", bus.step_o, 1'b0);
    check("reset done", bus.done_o, 1'b0);
    check("reset acc_rst", bus.acc_rst_o, 1'b0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // Continuous sweep: three full rounds of 0,10,20 with two cycles each, then abort.
    drive_cfg(1'b1, 1'b1, 32'd0, 32'd20, 32'd10, 16'd1);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      for (int h = 0; h < 2; h++) begin
        check($sformatf("cont k%0d h%0d p_inc", k, h), bus.p_inc_o, 32'((k % 3) * 10));
        check($sformatf("cont k%0d h%0d valid", k, h), bus.valid_o, 1'b1);
        check($sformatf("cont k%0d h%0d done", k, h), bus.done_o, 1'b0);
        check($sformatf("cont k%0d h%0d step", k, h), bus.step_o, (k > 0 && h == 0));
        exp_acc_rst($sformatf("cont k%0d h%0d acc_rst", k, h), (h == 0 && k % 3 == 0));
        tick();
      end
    end
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check("cont abort valid", bus.valid_o, 1'b0);
    check("cont abort done", bus.done_o, 1'b0);
    tick();
    check("cont after abort done", bus.done_o, 1'b0);

    // Abort in the second cycle of 110, then abort+start together in IDLE.
    drive_cfg(1'b0, 1'b1, 32'd100, 32'd130, 32'd10, 16'd2);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("abort pre p_inc", bus.p_inc_o, 32'd110);
    check("abort pre valid", bus.valid_o, 1'b1);
    bus.abort_i = 1'b1;
    tick();
    check("abort valid", bus.valid_o, 1'b0);
    check("abort busy", bus.busy_o, 1'b0);
    check("abort p_inc", bus.p_inc_o, 32'd110);
    check("abort done", bus.done_o, 1'b0);
    check("abort step", bus.step_o, 1'b0);
    bus.start_i = 1'b1;
    tick();
    check("abort+start valid", bus.valid_o, 1'b0);
    check("abort+start p_inc", bus.p_inc_o, 32'd110);
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    tick();
    check("post abort valid", bus.valid_o, 1'b0);
    check("post abort done", bus.done_o, 1'b0);

    // Asynchronous reset mid-dwell, then a fresh sweep.
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("pre reset p_inc", bus.p_inc_o, 32'd110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst p_inc", bus.p_inc_o, 32'd0);
    check("async rst valid", bus.valid_o, 1'b0);
    check("async rst busy", bus.busy_o, 1'b0);
    check("async rst step", bus.step_o, 1'b0);
    check("async rst done", bus.done_o, 1'b0);
    check("async rst acc_rst", bus.acc_rst_o, 1'b0);
    tick();
    check("in rst done", bus.done_o, 1'b0);
    rst_n = 1'b1;
    tick();
    run_vec(7, tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nco_sweep_ctrl
